// File: rtl/ring_lookahead_route_unit_pkg.sv
// Shared ring-NoC types: coordinates, one-hot hop directions and per-port packet state.
package noc;
    localparam int kRingSize = 8;
    localparam int kCoordW   = 4;

    typedef logic [kCoordW-1:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
    } xy_t;

    // One-hot hop direction; all-zero means "not yet resolved".
    typedef logic [2:0] direction_t;
    localparam int kEastPort  = 0;
    localparam int kWestPort  = 1;
    localparam int kLocalPort = 2;
    localparam direction_t goEast  = direction_t'(1 << kEastPort);
    localparam direction_t goWest  = direction_t'(1 << kWestPort);
    localparam direction_t goLocal = direction_t'(1 << kLocalPort);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } pkt_state_e;
endpackage

// File: rtl/ring_lookahead_route_unit_calc.sv
// ring_route_calc: combinational shortest-path choice on the ring plus the
// lookahead direction for the following router.
module ring_route_calc
    import noc::*;
#(
    parameter int RING_SIZE = kRingSize
) (
    input  coord_t     pos_x,
    input  coord_t     pos_next_x,
    input  coord_t     pos_prev_x,
    input  xy_t        dest,
    input  direction_t in_routing,
    input  logic       toggle,
    output direction_t routing,
    output direction_t next_routing,
    output logic       tie,
    output logic       bad_routing
);
    localparam int AW = $clog2(RING_SIZE) + 1;

    logic [AW-1:0] sum, dist_cw, dist_ccw;
    coord_t        next_x;
    logic          unused_dest_y;

    assign unused_dest_y = ^dest.y;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        routing      = '0;
        next_routing = '0;
        tie          = 1'b0;
        next_x       = '0;

        // dest + RING_SIZE - pos stays below 2*RING_SIZE, so AW bits hold it whole.
        sum         = AW'(dest.x) + AW'(RING_SIZE) - AW'(pos_x);
        dist_cw     = (sum >= AW'(RING_SIZE)) ? sum - AW'(RING_SIZE) : sum;
        dist_ccw    = AW'(RING_SIZE) - dist_cw;
        bad_routing = (in_routing != '0) && !$onehot(in_routing);

        if ((in_routing != '0) && !bad_routing) begin
            routing = in_routing;
        end else if (dist_cw == '0) begin
            routing = goLocal;
        end else if (dist_cw < dist_ccw) begin
            routing = goEast;
        end else if (dist_ccw < dist_cw) begin
            routing = goWest;
        end else begin
            tie     = 1'b1;
            routing = toggle ? goWest : goEast;
        end

        if (routing == goLocal) begin
            next_routing = goLocal;
        end else begin
            next_x       = (routing == goEast) ? pos_next_x : pos_prev_x;
            next_routing = (next_x == dest.x) ? goLocal : routing;
        end
    end
endmodule

// File: rtl/ring_lookahead_route_unit.sv
// Per-port lookahead route unit for a 1-D ring with one registered result per port.
// Optional macro RING_DATELINE_VC_EN: heads crossing the dateline move to VC 1.
module ring_lookahead_route_unit
    import noc::*;
#(
    parameter int RING_SIZE = kRingSize,
    parameter int NUM_PORTS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  xy_t                  position,
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    input  logic [NUM_PORTS-1:0] in_head,
    input  logic [NUM_PORTS-1:0] in_tail,
    input  xy_t                  in_dest          [NUM_PORTS],
    input  direction_t           in_routing       [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] in_vc,
    output logic [NUM_PORTS-1:0] out_valid,
    input  logic [NUM_PORTS-1:0] out_ready,
    output direction_t           out_routing      [NUM_PORTS],
    output direction_t           out_next_routing [NUM_PORTS],
    output logic [NUM_PORTS-1:0] out_vc,
    output logic [NUM_PORTS-1:0] err
);
    localparam int AW = $clog2(RING_SIZE) + 1;

    coord_t               pos_next_d, pos_next_q, pos_prev_d, pos_prev_q;
    logic                 pos_valid_d, pos_valid_q;
    logic [AW-1:0]        pos_w;
    pkt_state_e           state_d [NUM_PORTS], state_q [NUM_PORTS];
    direction_t           out_routing_d [NUM_PORTS], out_routing_q [NUM_PORTS];
    direction_t           out_next_d [NUM_PORTS], out_next_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] out_valid_d, out_valid_q, out_vc_d, out_vc_q;
    logic [NUM_PORTS-1:0] err_d, err_q, toggle_d, toggle_q, xfer, head_vc;
    direction_t           calc_routing [NUM_PORTS], calc_next [NUM_PORTS];
    logic [NUM_PORTS-1:0] calc_tie, calc_bad;
    logic                 unused_pos_y;

    assign unused_pos_y = ^position.y;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        ring_route_calc #(.RING_SIZE(RING_SIZE)) u_calc (
            .pos_x        (position.x),
            .pos_next_x   (pos_next_q),
            .pos_prev_x   (pos_prev_q),
            .dest         (in_dest[p]),
            .in_routing   (in_routing[p]),
            .toggle       (toggle_q[p]),
            .routing      (calc_routing[p]),
            .next_routing (calc_next[p]),
            .tie          (calc_tie[p]),
            .bad_routing  (calc_bad[p])
        );
    end

    assign in_ready = {NUM_PORTS{pos_valid_q}} & (~out_valid_q | out_ready);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        pos_w       = AW'(position.x);
        pos_next_d  = (pos_w == AW'(RING_SIZE - 1)) ? '0 : coord_t'(pos_w + 1'b1);
        pos_prev_d  = (pos_w == '0) ? coord_t'(RING_SIZE - 1) : coord_t'(pos_w - 1'b1);
        pos_valid_d = 1'b1;

        state_d       = state_q;
        out_routing_d = out_routing_q;
        out_next_d    = out_next_q;
        out_valid_d   = out_valid_q & ~out_ready;
        out_vc_d      = out_vc_q;
        err_d         = err_q;
        toggle_d      = toggle_q;
        head_vc       = in_vc;

        for (int p = 0; p < NUM_PORTS; p++) begin
`ifdef RING_DATELINE_VC_EN
            if (((calc_routing[p] == goEast) && (position.x == coord_t'(RING_SIZE - 1))) ||
                ((calc_routing[p] == goWest) && (position.x == '0))) begin
                head_vc[p] = 1'b1;
            end
`endif
            if (xfer[p]) begin
                out_valid_d[p] = 1'b1;
                if (in_head[p]) begin
                    // A head seen mid-packet is flagged but still restarts the packet.
                    out_routing_d[p] = calc_routing[p];
                    out_next_d[p]    = calc_next[p];
                    out_vc_d[p]      = head_vc[p];
                    err_d[p]         = err_q[p] | calc_bad[p] | (state_q[p] == ST_PKT);
                    toggle_d[p]      = toggle_q[p] ^ calc_tie[p];
                    state_d[p]       = in_tail[p] ? ST_IDLE : ST_PKT;
                end else if (state_q[p] == ST_IDLE) begin
                    out_routing_d[p] = in_routing[p];
                    out_next_d[p]    = in_routing[p];
                    out_vc_d[p]      = in_vc[p];
                    err_d[p]         = 1'b1;
                end else if (in_tail[p]) begin
                    state_d[p] = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignment so all flops sample together.
        pos_next_q <= pos_next_d;
        pos_prev_q <= pos_prev_d;
        if (rst) begin
            pos_valid_q   <= 1'b0;
            state_q       <= '{default: ST_IDLE};
            out_routing_q <= '{default: '0};
            out_next_q    <= '{default: '0};
            out_valid_q   <= '0;
            out_vc_q      <= '0;
            err_q         <= '0;
            toggle_q      <= '0;
        end else begin
            pos_valid_q   <= pos_valid_d;
            state_q       <= state_d;
            out_routing_q <= out_routing_d;
            out_next_q    <= out_next_d;
            out_valid_q   <= out_valid_d;
            out_vc_q      <= out_vc_d;
            err_q         <= err_d;
            toggle_q      <= toggle_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_routing      = out_routing_q;
    assign out_next_routing = out_next_q;
    assign out_vc           = out_vc_q;
    assign err              = err_q;
endmodule

// File: tb/tb_ring_lookahead_route_unit.sv
// Scoreboard bench: an 8-router instance and a 5-router instance, expectations queued per port.
module tb_ring_lookahead_route_unit;
    import noc::*;

    localparam int NP = 3;

    typedef struct packed {
        direction_t r;
        direction_t n;
        logic       vc;
    } exp_t;

`ifdef RING_DATELINE_VC_EN
    localparam bit DL = 1'b1;
`else
    localparam bit DL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xy_t           pos8, pos5;
    logic [NP-1:0] iv8, ir8, ih8, it8, ivc8, ov8, or8, ovc8, er8;
    logic [NP-1:0] iv5, ir5, ih5, it5, ivc5, ov5, or5, ovc5, er5;
    xy_t           id8 [NP], id5 [NP];
    direction_t    irt8 [NP], ort8 [NP], onr8 [NP];
    direction_t    irt5 [NP], ort5 [NP], onr5 [NP];

    exp_t q8 [NP][$];
    exp_t q5 [NP][$];
    int   errors = 0;
    int   checks = 0;

    ring_lookahead_route_unit #(.RING_SIZE(8), .NUM_PORTS(NP)) dut8 (
        .clk(clk), .rst(rst), .position(pos8),
        .in_valid(iv8), .in_ready(ir8), .in_head(ih8), .in_tail(it8),
        .in_dest(id8), .in_routing(irt8), .in_vc(ivc8),
        .out_valid(ov8), .out_ready(or8), .out_routing(ort8),
        .out_next_routing(onr8), .out_vc(ovc8), .err(er8)
    );

    ring_lookahead_route_unit #(.RING_SIZE(5), .NUM_PORTS(NP)) dut5 (
        .clk(clk), .rst(rst), .position(pos5),
        .in_valid(iv5), .in_ready(ir5), .in_head(ih5), .in_tail(it5),
        .in_dest(id5), .in_routing(irt5), .in_vc(ivc5),
        .out_valid(ov5), .out_ready(or5), .out_routing(ort5),
        .out_next_routing(onr5), .out_vc(ovc5), .err(er5)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            if (ov8[p] && or8[p]) begin
                if (q8[p].size() == 0) begin
                    check($sformatf("dut8 p%0d unexpected output", p), 1, 0);
                end else begin
                    e = q8[p].pop_front();
                    check($sformatf("dut8 p%0d route", p), ort8[p], e.r);
                    check($sformatf("dut8 p%0d next", p), onr8[p], e.n);
                    check($sformatf("dut8 p%0d vc", p), ovc8[p], e.vc);
                end
            end
            if (ov5[p] && or5[p]) begin
                if (q5[p].size() == 0) begin
                    check($sformatf("dut5 p%0d unexpected output", p), 1, 0);
                end else begin
                    e = q5[p].pop_front();
                    check($sformatf("dut5 p%0d route", p), ort5[p], e.r);
                    check($sformatf("dut5 p%0d next", p), onr5[p], e.n);
                    check($sformatf("dut5 p%0d vc", p), ovc5[p], e.vc);
                end
            end
        end
    end

    function automatic int pending();
        int n = 0;
        for (int p = 0; p < NP; p++) n += q8[p].size() + q5[p].size();
        return n;
    endfunction

    task automatic clear_queues();
        for (int p = 0; p < NP; p++) begin
            q8[p].delete();
            q5[p].delete();
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic send(input bit d5, input int p, input bit h, input bit t, input int dx,
                        input direction_t rt, input bit vc,
                        input direction_t er, input direction_t en, input bit evc);
        int  n = 0;
        bit  rdy;
        if (!d5) begin
            iv8[p] = 1'b1; ih8[p] = h; it8[p] = t; id8[p].x = coord_t'(dx);
            irt8[p] = rt; ivc8[p] = vc;
        end else begin
            iv5[p] = 1'b1; ih5[p] = h; it5[p] = t; id5[p].x = coord_t'(dx);
            irt5[p] = rt; ivc5[p] = vc;
        end
        @(negedge clk);
        rdy = d5 ? ir5[p] : ir8[p];
        while (!rdy && n < 64) begin
            n++;
            @(negedge clk);
            rdy = d5 ? ir5[p] : ir8[p];
        end
        if (!rdy) begin
            check($sformatf("send timeout dut%0d p%0d", d5 ? 5 : 8, p), 0, 1);
        end else if (!d5) begin
            q8[p].push_back('{r: er, n: en, vc: evc});
        end else begin
            q5[p].push_back('{r: er, n: en, vc: evc});
        end
        @(posedge clk);
        #1;
        if (!d5) iv8[p] = 1'b0;
        else     iv5[p] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (pending() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard drain", pending(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        iv8 = '0;
        iv5 = '0;
        clear_queues();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst  = 1'b1;
        pos8 = '0; pos8.x = 4'd2;
        pos5 = '0; pos5.x = 4'd4;
        iv8 = '0; ih8 = '0; it8 = '0; ivc8 = '0; or8 = '1;
        iv5 = '0; ih5 = '0; it5 = '0; ivc5 = '0; or5 = '1;
        for (int p = 0; p < NP; p++) begin
            id8[p] = '0; irt8[p] = '0;
            id5[p] = '0; irt5[p] = '0;
        end

        // Reset state and the one-cycle pos_valid delay.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out_valid", ov8, 0);
        check("reset err", er8, 0);
        check("reset in_ready", ir8, 0);
        check("reset out_routing", ort8[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready low before pos_valid", ir8, 0);
        @(negedge clk);
        check("in_ready high after pos_valid", ir8, 3'b111);
        @(posedge clk);
        #1;

        // Ring 8, pos 2: shortest path and lookahead.
        send(0, 0, 1, 1, 5, '0, 0, goEast, goEast, 0);
        send(0, 0, 1, 1, 3, '0, 0, goEast, goLocal, 0);
        send(0, 0, 1, 1, 2, '0, 0, goLocal, goLocal, 0);
        send(0, 0, 1, 1, 0, '0, 1, goWest, goWest, 1);
        send(0, 0, 1, 1, 1, '0, 0, goWest, goLocal, 0);
        send(0, 0, 1, 1, 5, goWest, 0, goWest, goWest, 0);

        // Ring 5, pos 4: pre-routed east head wraps to x=0, dateline VC on the whole packet.
        send(1, 0, 1, 0, 0, goEast, 0, goEast, goLocal, DL);
        send(1, 0, 0, 0, 3, goWest, 0, goEast, goLocal, DL);
        send(1, 0, 0, 1, 3, goWest, 0, goEast, goLocal, DL);
        send(1, 1, 1, 1, 1, '0, 0, goEast, goEast, DL);
        send(1, 1, 1, 1, 2, '0, 1, goWest, goWest, 1);
        send(1, 1, 1, 1, 4, '0, 0, goLocal, goLocal, 0);
        drain();
        check("no err ring8", er8, 0);
        check("no err ring5", er5, 0);

        // 4-flit packet under 3 cycles of backpressure; body flits carry misleading dest/routing.
        or8[0] = 1'b0;
        fork
            begin
                send(0, 0, 1, 0, 1, '0, 0, goWest, goLocal, 0);
                send(0, 0, 0, 0, 5, goEast, 0, goWest, goLocal, 0);
                send(0, 0, 0, 0, 6, goEast, 0, goWest, goLocal, 0);
                send(0, 0, 0, 1, 7, goEast, 0, goWest, goLocal, 0);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!ov8[0] && n < 20) begin
                    n++;
                    @(negedge clk);
                end
                check("stall head appeared", ov8[0], 1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("stall%0d out_valid", i), ov8[0], 1);
                    check($sformatf("stall%0d route", i), ort8[0], goWest);
                    check($sformatf("stall%0d next", i), onr8[0], goLocal);
                    check($sformatf("stall%0d in_ready", i), ir8[0], 0);
                end
                @(posedge clk);
                #1;
                or8[0] = 1'b1;
            end
        join
        drain();

        // Ring 8, pos 0: equal-distance ties alternate per port.
        pos8.x = 4'd0;
        do_reset();
        send(0, 0, 1, 1, 4, '0, 0, goEast, goEast, 0);
        send(0, 0, 1, 1, 4, '0, 0, goWest, goWest, 0);
        send(0, 0, 1, 1, 4, '0, 0, goEast, goEast, 0);
        send(0, 1, 1, 1, 4, '0, 0, goEast, goEast, 0);
        drain();

        // Protocol errors: stray body, bad one-hot routing, head inside a packet.
        pos8.x = 4'd2;
        do_reset();
        check("err clear after reset", er8, 0);
        send(0, 0, 0, 0, 5, '0, 0, '0, '0, 0);
        drain();
        check("err on body in IDLE", er8[0], 1);
        send(0, 0, 1, 1, 5, '0, 0, goEast, goEast, 0);
        drain();
        check("err sticky", er8[0], 1);
        send(0, 1, 1, 1, 5, 3'b011, 0, goEast, goEast, 0);
        drain();
        check("err on bad routing", er8[1], 1);
        send(0, 2, 1, 0, 3, '0, 0, goEast, goLocal, 0);
        send(0, 2, 1, 1, 1, '0, 0, goWest, goLocal, 0);
        drain();
        check("err on head in PKT", er8[2], 1);

        // Reset in the middle of a packet.
        or8[0] = 1'b0;
        send(0, 0, 1, 0, 5, '0, 1, goEast, goEast, 1);
        @(negedge clk);
        check("mid-packet head held", ov8[0], 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_queues();
        @(posedge clk);
        @(negedge clk);
        check("rst out_valid", ov8, 0);
        check("rst out_routing", ort8[0], 0);
        check("rst out_next", onr8[0], 0);
        check("rst out_vc", ovc8, 0);
        check("rst err", er8, 0);
        check("rst in_ready", ir8, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-rst in_ready low", ir8, 0);
        check("post-rst out_valid", ov8, 0);
        @(negedge clk);
        check("post-rst in_ready high", ir8, 3'b111);
        @(posedge clk);
        #1;
        or8[0] = 1'b1;
        send(0, 0, 0, 1, 5, '0, 0, '0, '0, 0);
        drain();
        check("packet discarded by rst", er8[0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ring_lookahead_route_unit.md
RING_LOOKAHEAD_ROUTE_UNIT -- requirements
Module: ring_lookahead_route_unit

Interface
REQ-001 SHALL have parameter RING_SIZE, default 8: number of routers on the ring, any value >= 3.
REQ-002 SHALL have parameter NUM_PORTS, default 3: independent input channels served in parallel.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port position, input, noc::xy_t: static router coordinate.
REQ-006 SHALL have ports in_valid and in_ready, input and output, [NUM_PORTS]: per-port flit handshake.
REQ-007 SHALL have ports in_head and in_tail, input, [NUM_PORTS]: flit type; head plus tail together marks a single-flit packet.
REQ-008 SHALL have port in_dest, input, noc::xy_t [NUM_PORTS]: destination, sampled on head flits only.
REQ-009 SHALL have port in_routing, input, noc::direction_t [NUM_PORTS]: routing for this hop, where all-zero means unresolved (local injection).
REQ-010 SHALL have port in_vc, input, [NUM_PORTS] 1 bit: incoming virtual channel.
REQ-011 SHALL have ports out_valid and out_ready, output and input, [NUM_PORTS]: result handshake.
REQ-012 SHALL have port out_routing, output, noc::direction_t [NUM_PORTS]: resolved routing for this hop.
REQ-013 SHALL have port out_next_routing, output, noc::direction_t [NUM_PORTS]: lookahead routing for the next hop.
REQ-014 SHALL have port out_vc, output, [NUM_PORTS]: outgoing VC.
REQ-015 SHALL have port err, output, [NUM_PORTS]: sticky protocol error flag.

Function
REQ-016 SHALL register position + 1 mod RING_SIZE and position + RING_SIZE - 1 mod RING_SIZE every cycle, with a pos_valid flag set one cycle after reset deasserts.
REQ-017 SHALL hold in_ready low while pos_valid = 0; otherwise in_ready = !out_valid | out_ready.
REQ-018 SHALL register one result per port with latency 1: a transfer on the in handshake in cycle N makes out_valid high in cycle N+1, and the result holds stable until out_ready.
REQ-019 SHALL keep a two-state FSM per port, IDLE and PKT: a head without tail moves IDLE->PKT, a tail moves PKT->IDLE, and a head plus tail stays in IDLE.
REQ-020 SHALL resolve an unresolved head from dist_cw = (dest.x - pos.x) mod RING_SIZE and dist_ccw = RING_SIZE - dist_cw: dist_cw = 0 gives goLocal, dist_cw < dist_ccw gives goEast, dist_ccw < dist_cw gives goWest.
REQ-021 SHALL break an equal-distance tie (even RING_SIZE only) using a per-port toggle bit, reset to 0: 0 gives goEast, 1 gives goWest, and the bit inverts after each tie decision.
REQ-022 SHALL set out_next_routing to goLocal when the next-hop x equals dest.x, and otherwise copy the resolved direction; a goLocal hop SHALL give goLocal.
REQ-023 SHALL latch routing, next routing and VC per port at the head; body and tail flits SHALL reuse the latched values and ignore in_dest and in_routing.
REQ-024 SHALL respond to a non-head flit in IDLE, or a head in PKT, by setting err[p] sticky and passing the flit with its values unchanged; a head in PKT SHALL restart the packet.
REQ-025 SHALL compute wrap arithmetic at width $clog2(RING_SIZE)+1 with no truncation before the modulo.
REQ-026 SHALL reject a non-one-hot, non-zero in_routing on a head by setting err and resolving it as unresolved.

Reset
REQ-027 SHALL clear on rst: out_valid = 0, all out_* = 0, err = 0, FSMs = IDLE, toggle bits = 0, pos_valid = 0; rst mid-packet discards the packet.

Configuration
REQ-028 SHALL define RING_DATELINE_VC_EN: when defined, a head crossing the dateline (goEast at pos.x = RING_SIZE-1, or goWest at pos.x = 0) forces out_vc = 1, and otherwise out_vc = in_vc, latched per packet.
REQ-029 SHALL, without RING_DATELINE_VC_EN, drive out_vc = in_vc with no dateline logic.

Structure
REQ-030 SHALL place kRingSize, xy_t, direction_t, goEast, goWest, goLocal, kEastPort and kWestPort in package noc.
REQ-031 SHALL use one sub-module, ring_route_calc: combinational shortest-path and lookahead computation, instantiated per port.

Verification
REQ-032 SHALL cover: RING_SIZE = 8, pos = 2, unresolved head dest = 5 -> out_routing goEast, out_next_routing goEast; dest = 3 -> goEast, next goLocal.
REQ-033 SHALL cover: RING_SIZE = 8, pos = 0, two unresolved heads dest = 4 -> first goEast, second goWest.
REQ-034 SHALL cover: RING_SIZE = 5, pos = 4, head goEast, dest = 0 -> next goLocal; with RING_DATELINE_VC_EN defined, out_vc = 1 for head, body and tail.
REQ-035 SHALL cover: a 4-flit packet with out_ready low for 3 cycles -> outputs stable, in_ready low, no flit lost, and body flits keep the head's route.
REQ-036 SHALL cover: a body flit in IDLE -> err = 1 and stays 1; rst mid-packet -> all outputs 0 and in_ready low for 1 cycle.
